// File: rtl/ex_mem_branch_resolve_if.sv
// EX/MEM stage bus: EX-side inputs, MEM-side latched fields,
// redirect, predictor update and branch statistics.
interface ex_mem_branch_resolve_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic [31:0]      ex_res;
    logic             ex_zero;
    logic [31:0]      ex_store_data;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_is_branch;
    logic             ex_br_ne;
    logic             ex_pred_taken;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_br_target;
    logic             mem_stall;

    logic             mem_valid;
    logic [31:0]      mem_alu_res;
    logic [31:0]      mem_store_data;
    logic [REG_W-1:0] mem_rd;
    logic             mem_reg_write;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             bp_upd_valid;
    logic [31:0]      bp_upd_pc;
    logic             bp_upd_taken;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        input  ex_valid, ex_res, ex_zero, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write,
               ex_is_branch, ex_br_ne, ex_pred_taken,
               ex_pc, ex_br_target, mem_stall,
        output mem_valid, mem_alu_res, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write,
               redirect_valid, redirect_pc, flush,
               bp_upd_valid, bp_upd_pc, bp_upd_taken,
               br_count, mispred_count
    );

    modport slave (
        output ex_valid, ex_res, ex_zero, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write,
               ex_is_branch, ex_br_ne, ex_pred_taken,
               ex_pc, ex_br_target, mem_stall,
        input  mem_valid, mem_alu_res, mem_store_data, mem_rd,
               mem_reg_write, mem_mem_read, mem_mem_write,
               redirect_valid, redirect_pc, flush,
               bp_upd_valid, bp_upd_pc, bp_upd_taken,
               br_count, mispred_count
    );
endinterface

// File: rtl/ex_mem_branch_resolve.sv
// EX/MEM pipeline register with branch resolution, redirect,
// wrong-path squash and saturating branch statistics.
module ex_mem_branch_resolve #(
    parameter int REG_W        = 5,
    parameter int PC_INC       = 4,
    parameter int SQUASH_SLOTS = 2,
    parameter int CNT_W        = 32
) (
    input logic                     clk,
    input logic                     rst,
    ex_mem_branch_resolve_if.master bus
);
    typedef enum logic {RUN, SQUASH} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic        accept;
    logic        taken;
    logic        mispredict;
    logic        resolve;
    logic [31:0] corr_pc;

    logic             valid_q;
    logic [31:0]      res_q;
    logic [31:0]      sd_q;
    logic [REG_W-1:0] rd_q;
    logic             rw_q, mr_q, mw_q;
    logic             redir_q;
    logic [31:0]      redir_pc_q;
    logic             upd_q;
    logic [31:0]      upd_pc_q;
    logic             upd_taken_q;
    logic [CNT_W-1:0] br_q, mis_q;

    assign accept     = bus.ex_valid & ~bus.mem_stall
                      & (state_q == RUN);
    assign taken      = bus.ex_br_ne ? ~bus.ex_zero : bus.ex_zero;
    assign resolve    = accept & bus.ex_is_branch;
    assign mispredict = resolve & (taken != bus.ex_pred_taken);
    assign corr_pc    = taken ? bus.ex_br_target
                              : bus.ex_pc + 32'(PC_INC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.mem_stall) begin
            unique case (1'b1)
                (state_q == RUN): begin
                    if (mispredict) begin
                        state_d = SQUASH;
                        cnt_d   = 3'(SQUASH_SLOTS);
                    end
                end
                (state_q == SQUASH): begin
                    // last dropped slot returns to RUN
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else if (!bus.mem_stall) begin
            valid_q <= accept;
            res_q   <= bus.ex_res;
            sd_q    <= bus.ex_store_data;
            rd_q    <= bus.ex_rd;
            rw_q    <= bus.ex_reg_write & accept;
            mr_q    <= bus.ex_mem_read & accept;
            mw_q    <= bus.ex_mem_write & accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_q     <= 1'b0;
            redir_pc_q  <= '0;
            upd_q       <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            br_q        <= '0;
            mis_q       <= '0;
        end else begin
            redir_q <= mispredict;
            upd_q   <= resolve;
            if (mispredict)
                redir_pc_q <= corr_pc;
            if (resolve) begin
                upd_pc_q    <= bus.ex_pc;
                upd_taken_q <= taken;
            end
            if (resolve && br_q != '1)
                br_q <= br_q + 1'b1;
            if (mispredict && mis_q != '1)
                mis_q <= mis_q + 1'b1;
        end
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_res    = res_q;
    assign bus.mem_store_data = sd_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = rw_q;
    assign bus.mem_mem_read   = mr_q;
    assign bus.mem_mem_write  = mw_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.flush          = redir_q;
    assign bus.bp_upd_valid   = upd_q;
    assign bus.bp_upd_pc      = upd_pc_q;
    assign bus.bp_upd_taken   = upd_taken_q;
    assign bus.br_count       = br_q;
    assign bus.mispred_count  = mis_q;
endmodule

// File: tb/tb_ex_mem_branch_resolve.sv
// Directed bench for ex_mem_branch_resolve: prediction outcomes,
// squash window, stall freeze, async reset and counter saturation.
module tb_ex_mem_branch_resolve;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    ex_mem_branch_resolve_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    ex_mem_branch_resolve #(
        .REG_W(REG_W), .PC_INC(4), .SQUASH_SLOTS(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.ex_valid      = 1'b0;
        bus.ex_res        = '0;
        bus.ex_zero       = 1'b0;
        bus.ex_store_data = '0;
        bus.ex_rd         = '0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_is_branch  = 1'b0;
        bus.ex_br_ne      = 1'b0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pc         = '0;
        bus.ex_br_target  = '0;
        bus.mem_stall     = 1'b0;
    endtask

    task automatic branch(input logic ne, input logic zero,
                          input logic pred, input logic [31:0] pc,
                          input logic [31:0] tgt);
        idle();
        bus.ex_valid      = 1'b1;
        bus.ex_is_branch  = 1'b1;
        bus.ex_br_ne      = ne;
        bus.ex_zero       = zero;
        bus.ex_pred_taken = pred;
        bus.ex_pc         = pc;
        bus.ex_br_target  = tgt;
    endtask

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_res       = res;
        bus.ex_rd        = rd;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_write = 1'b1;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        step();
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_redirect", bus.redirect_valid, 0);
        chk("rst_redirect_pc", bus.redirect_pc, 0);
        chk("rst_br_count", bus.br_count, 0);
        rst = 1'b0;

        // 1: correct BNE prediction
        branch(1'b1, 1'b0, 1'b1, 32'h200, 32'h300);
        step();
        chk("t1_redirect", bus.redirect_valid, 0);
        chk("t1_upd_valid", bus.bp_upd_valid, 1);
        chk("t1_upd_taken", bus.bp_upd_taken, 1);
        chk("t1_upd_pc", bus.bp_upd_pc, 32'h200);
        chk("t1_br_count", bus.br_count, 1);
        chk("t1_mis_count", bus.mispred_count, 0);
        chk("t1_mem_valid", bus.mem_valid, 1);

        // 2: BEQ mispredicted not-taken, then squash window
        do_reset();
        branch(1'b0, 1'b1, 1'b0, 32'h100, 32'h140);
        step();
        chk("t2_redirect", bus.redirect_valid, 1);
        chk("t2_flush", bus.flush, 1);
        chk("t2_redirect_pc", bus.redirect_pc, 32'h140);
        chk("t2_mis_count", bus.mispred_count, 1);
        branch(1'b0, 1'b0, 1'b1, 32'h144, 32'h400);
        bus.ex_reg_write = 1'b1;
        step();
        chk("t2_sq1_valid", bus.mem_valid, 0);
        chk("t2_sq1_rw", bus.mem_reg_write, 0);
        chk("t2_sq1_redirect", bus.redirect_valid, 0);
        chk("t2_sq1_upd", bus.bp_upd_valid, 0);
        chk("t2_sq1_br_count", bus.br_count, 1);
        alu(32'h11, 5'd9);
        step();
        chk("t2_sq2_valid", bus.mem_valid, 0);
        chk("t2_sq2_rw", bus.mem_reg_write, 0);
        chk("t2_sq2_mw", bus.mem_mem_write, 0);
        alu(32'h22, 5'd10);
        step();
        chk("t2_post_valid", bus.mem_valid, 1);
        chk("t2_post_rw", bus.mem_reg_write, 1);
        chk("t2_post_res", bus.mem_alu_res, 32'h22);
        chk("t2_post_redir_pc", bus.redirect_pc, 32'h140);

        // 3: BEQ mispredicted taken, falls through
        do_reset();
        branch(1'b0, 1'b0, 1'b1, 32'h200, 32'h280);
        step();
        chk("t3_redirect", bus.redirect_valid, 1);
        chk("t3_redirect_pc", bus.redirect_pc, 32'h204);
        chk("t3_upd_taken", bus.bp_upd_taken, 0);

        // 4: ALU op, then stalled mispredicting BEQ
        do_reset();
        alu(32'h5, 5'd3);
        bus.ex_mem_write = 1'b0;
        step();
        chk("t4_res", bus.mem_alu_res, 5);
        chk("t4_rd", bus.mem_rd, 3);
        chk("t4_rw", bus.mem_reg_write, 1);
        chk("t4_valid", bus.mem_valid, 1);
        branch(1'b0, 1'b1, 1'b0, 32'h100, 32'h180);
        bus.ex_res    = 32'h77;
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_res", bus.mem_alu_res, 5);
            chk("t4_stall_valid", bus.mem_valid, 1);
            chk("t4_stall_redirect", bus.redirect_valid, 0);
            chk("t4_stall_upd", bus.bp_upd_valid, 0);
        end
        chk("t4_stall_br_count", bus.br_count, 0);
        bus.mem_stall = 1'b0;
        step();
        chk("t4_redirect", bus.redirect_valid, 1);
        chk("t4_redirect_pc", bus.redirect_pc, 32'h180);
        chk("t4_res_after", bus.mem_alu_res, 32'h77);

        // 5: async reset with one squash slot left
        idle();
        step();
        chk("t5_in_squash", bus.mem_valid, 0);
        rst = 1'b1;
        #2;
        chk("t5_rst_redirect_pc", bus.redirect_pc, 0);
        chk("t5_rst_br_count", bus.br_count, 0);
        chk("t5_rst_mis_count", bus.mispred_count, 0);
        chk("t5_rst_res", bus.mem_alu_res, 0);
        chk("t5_rst_upd_pc", bus.bp_upd_pc, 0);
        rst = 1'b0;
        alu(32'h9, 5'd7);
        step();
        chk("t5_accept", bus.mem_valid, 1);
        chk("t5_rd", bus.mem_rd, 7);

        // 6: counter saturation at 15
        do_reset();
        for (int i = 0; i < 20; i++) begin
            branch(1'b1, 1'b1, 1'b1, 32'h300, 32'h500);
            step();
            idle();
            step();
            step();
        end
        chk("t6_br_count", bus.br_count, 15);
        chk("t6_mis_count", bus.mispred_count, 15);
        branch(1'b1, 1'b1, 1'b1, 32'h300, 32'h500);
        step();
        chk("t6_hold_redirect", bus.redirect_valid, 1);
        chk("t6_hold_redir_pc", bus.redirect_pc, 32'h304);
        chk("t6_hold_br", bus.br_count, 15);
        chk("t6_hold_mis", bus.mispred_count, 15);

        // non-branch with prediction bit set never redirects
        idle();
        step();
        step();
        alu(32'h1, 5'd1);
        bus.ex_pred_taken = 1'b1;
        step();
        chk("nb_redirect", bus.redirect_valid, 0);
        chk("nb_upd", bus.bp_upd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_branch_resolve.md
Name: ex_mem_branch_resolve

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Latches the ALU result and the store/destination fields into the EX/MEM register.
- Resolves conditional branches from the ALU Zero flag against the fetch-stage prediction. On a mispredict it issues a one-cycle redirect/flush, then squashes the wrong-path instructions already in flight.
- Produces predictor-update pulses and saturating branch/mispredict statistics.

Parameters:
- REG_W, 5, destination register index width.
- PC_INC, 4, fall-through increment added to ex_pc.
- SQUASH_SLOTS, 2, wrong-path EX slots dropped after a redirect; legal range 1..7.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX slot holds an instruction.
- ex_res  in  32  ALU RES.
- ex_zero  in  1  ALU Zero.
- ex_store_data  in  32  store operand.
- ex_rd  in  REG_W  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits.
- ex_is_branch  in  1  conditional branch in EX.
- ex_br_ne  in  1  0 = BEQ (taken on Zero), 1 = BNE (taken on !Zero).
- ex_pred_taken  in  1  fetch prediction.
- ex_pc  in  32  branch PC.
- ex_br_target  in  32  taken target.
- mem_stall  in  1  memory stage busy; freeze this stage.
- mem_valid  out  1  EX/MEM slot valid.
- mem_alu_res  out  32  latched result.
- mem_store_data  out  32  latched store data.
- mem_rd  out  REG_W  latched destination.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  latched controls, gated by validity.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  corrected fetch PC.
- flush  out  1  flush IF/ID; equal to redirect_valid.
- bp_upd_valid  out  1  predictor update pulse.
- bp_upd_pc  out  32  PC of resolved branch.
- bp_upd_taken  out  1  actual outcome.
- br_count  out  CNT_W  resolved branches, saturating.
- mispred_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (async, rst=1): every output = 0, FSM = RUN, squash counter = 0. Applies immediately, including mid-SQUASH. First edge after release behaves as RUN.
- accept = ex_valid & !mem_stall & (state==RUN).
- taken = ex_br_ne ? !ex_zero : ex_zero.
- mispredict = accept & ex_is_branch & (taken != ex_pred_taken).
- Corrected PC = taken ? ex_br_target : ex_pc + PC_INC. Addition is 32-bit modulo; wrap-around is ignored.
- Edge with mem_stall=0:
  - mem_alu_res, mem_store_data, mem_rd <= ex fields.
  - mem_valid <= accept.
  - The three mem control bits <= ex control bit & accept, so squashed or invalid slots are inert bubbles.
- Edge with mem_stall=1:
  - All mem_* outputs hold.
  - State and squash counter hold.
  - redirect_valid, flush and bp_upd_valid <= 0.
  - No counter updates.
  - A branch in EX is resolved on the first non-stalled edge.
- Latency: 1 cycle from EX to every registered output.
- redirect_valid/flush <= mispredict, and redirect_pc <= the corrected PC. When there is no redirect, redirect_pc holds its last value.
- bp_upd_valid <= accept & ex_is_branch. bp_upd_pc/bp_upd_taken are loaded on the same condition.
- br_count increments on accept & ex_is_branch; mispred_count increments on mispredict. Both saturate at 2^CNT_W-1 and never wrap.
- FSM:
  - RUN: on mispredict, go to SQUASH and load cnt = SQUASH_SLOTS.
  - SQUASH: each non-stalled edge decrements cnt. Every EX slot is dropped, whether or not ex_valid=1: mem_valid=0, no redirect, no bp update, no count. Wrong-path branches, including would-be mispredicts, are ignored. When cnt reaches 0, go to RUN.
  - Consequence: exactly SQUASH_SLOTS non-stalled edges are dropped after the mispredict edge.
- A non-branch instruction with ex_is_branch=0 never redirects, regardless of ex_pred_taken.

Test Plan:
1. Correct prediction. BNE, ex_pred_taken=1, ex_zero=0, ex_pc=0x200 -> next cycle: redirect_valid=0, bp_upd_valid=1, bp_upd_taken=1, bp_upd_pc=0x200, br_count=1, mispred_count=0.
2. Mispredict, actual taken. BEQ, ex_pred_taken=0, ex_zero=1, ex_pc=0x100, target=0x140 -> next cycle: redirect_valid=flush=1, redirect_pc=0x140, mispred_count=1. The next 2 valid instructions give mem_valid=0 and all mem control bits 0; the third gives mem_valid=1.
3. Mispredict, actual not taken. BEQ, ex_pred_taken=1, ex_zero=0, ex_pc=0x200 -> redirect_pc=0x204, bp_upd_taken=0.
4. ALU op with stall. ex_res=0x5, ex_rd=3, reg_write=1 -> mem_alu_res=5, mem_rd=3, mem_reg_write=1, mem_valid=1. Then raise mem_stall for 3 cycles with a mispredicting BEQ in EX -> outputs unchanged and redirect_valid=0 throughout. redirect_valid=1 on the cycle after mem_stall drops.
5. Reset mid-squash. Assert rst while in SQUASH with cnt=1 -> all outputs 0 without waiting for a clock. After release, the next valid instruction is accepted (mem_valid=1).
6. Saturation. With CNT_W=4, issue 20 mispredicting branches separated by squash bubbles -> br_count=15 and mispred_count=15, both holding.
